cl_decode_stage: RTL and testbench

Registered decode stage with load-use interlock for the pipelined core. It sits between fetch and register-read/execute and emits a control bundle per instruction: load, rf-write, store, mem, byte and new illegal flags. Output is a valid/ready pipeline register. A SB_DEPTH-entry scoreboard of in-flight destinations inserts bubbles when an instruction reads a register still waiting on a load. A saturating stall counter supports performance measurement.

---
 rtl/cl_decode_pkg.sv | 62 ++++++
 rtl/definitions.sv | 36 +++
 rtl/cl_decode_ctrl.sv | 17 +
 rtl/cl_decode_stage.sv | 120 ++++++++++++
 tb/tb_cl_decode_stage.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cl_decode_pkg.sv
// Decode control bundle, scoreboard entry type and the opcode-to-flags function.
package cl_decode_pkg;
    import definitions::*;

    typedef struct packed {
        logic is_load;
        logic writes_rf;
        logic is_store;
        logic is_mem;
        logic is_byte;
        logic is_illegal;
    } decode_ctrl_s;

    typedef struct packed {
        logic                  valid;
        logic                  is_load;
        logic [REG_ADDR_W-1:0] rd;
    } sb_entry_s;

    // Illegal instructions carry no other flag so nothing downstream acts on them.
    function automatic decode_ctrl_s cl_decode(input logic [OPCODE_W-1:0] op,
                                               input logic byte_en);
        decode_ctrl_s c;
        c = '0;
        case (op)
            kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR, kSLT, kSLTU,
            kMOV, kSLLR, kJALR, kXOR, kROR: c.writes_rf = 1'b1;
            kLW: begin
                c.is_load   = 1'b1;
                c.writes_rf = 1'b1;
                c.is_mem    = 1'b1;
            end
            kLBU: begin
                if (byte_en) begin
                    c.is_load   = 1'b1;
                    c.writes_rf = 1'b1;
                    c.is_mem    = 1'b1;
                    c.is_byte   = 1'b1;
                end else begin
                    c.is_illegal = 1'b1;
                end
            end
            kSW: begin
                c.is_store = 1'b1;
                c.is_mem   = 1'b1;
            end
            kSB: begin
                if (byte_en) begin
                    c.is_store = 1'b1;
                    c.is_mem   = 1'b1;
                    c.is_byte  = 1'b1;
                end else begin
                    c.is_illegal = 1'b1;
                end
            end
            kBEQZ, kBNEQZ, kJ: c = '0;
            default: c.is_illegal = 1'b1;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/definitions.sv
// Core-wide instruction format and opcode patterns shared across pipeline stages.
package definitions;

    localparam int REG_ADDR_W = 5;
    localparam int OPCODE_W   = 6;

    typedef struct packed {
        logic [OPCODE_W-1:0]   opcode;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs_imm;
    } instruction_s;

    localparam logic [OPCODE_W-1:0] kADDU  = 6'h01;
    localparam logic [OPCODE_W-1:0] kSUBU  = 6'h02;
    localparam logic [OPCODE_W-1:0] kSLLV  = 6'h03;
    localparam logic [OPCODE_W-1:0] kSRAV  = 6'h04;
    localparam logic [OPCODE_W-1:0] kSRLV  = 6'h05;
    localparam logic [OPCODE_W-1:0] kAND   = 6'h06;
    localparam logic [OPCODE_W-1:0] kOR    = 6'h07;
    localparam logic [OPCODE_W-1:0] kNOR   = 6'h08;
    localparam logic [OPCODE_W-1:0] kSLT   = 6'h09;
    localparam logic [OPCODE_W-1:0] kSLTU  = 6'h0A;
    localparam logic [OPCODE_W-1:0] kMOV   = 6'h0B;
    localparam logic [OPCODE_W-1:0] kSLLR  = 6'h0C;
    localparam logic [OPCODE_W-1:0] kJALR  = 6'h0D;
    localparam logic [OPCODE_W-1:0] kLW    = 6'h0E;
    localparam logic [OPCODE_W-1:0] kLBU   = 6'h0F;
    localparam logic [OPCODE_W-1:0] kXOR   = 6'h10;
    localparam logic [OPCODE_W-1:0] kROR   = 6'h11;
    localparam logic [OPCODE_W-1:0] kSW    = 6'h12;
    localparam logic [OPCODE_W-1:0] kSB    = 6'h13;
    localparam logic [OPCODE_W-1:0] kBEQZ  = 6'h14;
    localparam logic [OPCODE_W-1:0] kBNEQZ = 6'h15;
    localparam logic [OPCODE_W-1:0] kJ     = 6'h16;

endpackage

// File: rtl/cl_decode_ctrl.sv
// Combinational flag decode of one instruction.
module cl_decode_ctrl
    import definitions::*;
    import cl_decode_pkg::*;
#(
    parameter int BYTE_OPS_EN = 1
) (
    input  instruction_s instr_i,
    output decode_ctrl_s ctrl_o
);

    // Byte ops become illegal when the memory path has no byte lanes.
    always_comb begin
        ctrl_o = cl_decode(instr_i.opcode, BYTE_OPS_EN != 0);
    end

endmodule

// File: rtl/cl_decode_stage.sv
// Registered decode stage with load-use interlock and hazard-stall counter.
// SB_DEPTH must be at least 1; slot 0 always mirrors the output register.
module cl_decode_stage
    import definitions::*;
    import cl_decode_pkg::*;
#(
    parameter int SB_DEPTH    = 2,
    parameter int BYTE_OPS_EN = 1,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  instruction_s           instruction_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output instruction_s           instr_o,
    output decode_ctrl_s           ctrl_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    decode_ctrl_s            in_ctrl;
    logic                    hazard;
    logic                    load_en;
    logic                    accept;

    logic                    out_valid_q, out_valid_d;
    instruction_s            instr_q,     instr_d;
    decode_ctrl_s            ctrl_q,      ctrl_d;
    sb_entry_s               sb_q [SB_DEPTH];
    sb_entry_s               sb_d [SB_DEPTH];
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    cl_decode_ctrl #(
        .BYTE_OPS_EN (BYTE_OPS_EN)
    ) u_decode_ctrl (
        .instr_i (instruction_i),
        .ctrl_o  (in_ctrl)
    );

    // Conservative load-use check: both register fields compared regardless of opcode.
    always_comb begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            if (sb_q[i].valid && sb_q[i].is_load &&
                (sb_q[i].rd == instruction_i.rd || sb_q[i].rd == instruction_i.rs_imm)) begin
                hit = 1'b1;
            end
        end
        hazard     = in_valid_i && !in_ctrl.is_illegal && hit;
        load_en    = out_ready_i || !out_valid_q;
        in_ready_o = !flush_i && !hazard && load_en;
        accept     = in_valid_i && in_ready_o;
    end

    // Next state: flush squashes everything; slots beyond 0 only age when downstream advances.
    always_comb begin
        out_valid_d = out_valid_q;
        instr_d     = instr_q;
        ctrl_d      = ctrl_q;
        sb_d        = sb_q;
        stall_cnt_d = stall_cnt_q;
        if (flush_i) begin
            out_valid_d = 1'b0;
            ctrl_d      = '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_d[i] = '0;
            end
        end else if (load_en) begin
            if (out_ready_i) begin
                for (int i = 1; i < SB_DEPTH; i++) begin
                    sb_d[i] = sb_q[i-1];
                end
            end
            if (accept) begin
                out_valid_d = 1'b1;
                instr_d     = instruction_i;
                ctrl_d      = in_ctrl;
                sb_d[0]     = '{valid: 1'b1, is_load: in_ctrl.is_load, rd: instruction_i.rd};
            end else begin
                out_valid_d = 1'b0;
                ctrl_d      = '0;
                sb_d[0]     = '0;
            end
        end
        if (hazard && !flush_i && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            ctrl_q      <= '0;
            stall_cnt_q <= '0;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            ctrl_q      <= ctrl_d;
            stall_cnt_q <= stall_cnt_d;
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_q[i] <= sb_d[i];
            end
        end
    end

    assign out_valid_o = out_valid_q;
    assign instr_o     = instr_q;
    assign ctrl_o      = ctrl_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_cl_decode_stage.sv
// Bench for cl_decode_stage: scoreboard of expected outputs plus directed interlock cases.
module tb_cl_decode_stage;
    import definitions::*;
    import cl_decode_pkg::*;

    typedef struct packed {
        instruction_s instr;
        decode_ctrl_s ctrl;
    } exp_t;

    localparam logic [OPCODE_W-1:0] kUNDEF = 6'h3F;

    logic          clk;
    logic          n_reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    instruction_s  in_instr;

    logic          in_ready_o,  nb_in_ready;
    logic          out_valid_o, nb_out_valid;
    instruction_s  instr_o,     nb_instr;
    decode_ctrl_s  ctrl_o,      nb_ctrl;
    logic [15:0]   stall_cnt_o, nb_stall;

    exp_t          exp_q[$];
    int            n_chk = 0;
    int            n_err = 0;

    cl_decode_stage dut (
        .clk           (clk),
        .n_reset       (n_reset),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready_o),
        .instruction_i (in_instr),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready),
        .instr_o       (instr_o),
        .ctrl_o        (ctrl_o),
        .stall_cnt_o   (stall_cnt_o)
    );

    cl_decode_stage #(.BYTE_OPS_EN(0)) dut_nb (
        .clk           (clk),
        .n_reset       (n_reset),
        .flush_i       (flush),
        .in_valid_i    (in_valid),
        .in_ready_o    (nb_in_ready),
        .instruction_i (in_instr),
        .out_valid_o   (nb_out_valid),
        .out_ready_i   (out_ready),
        .instr_o       (nb_instr),
        .ctrl_o        (nb_ctrl),
        .stall_cnt_o   (nb_stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic instruction_s mk(input logic [OPCODE_W-1:0] op,
                                        input int rd, input int rs);
        instruction_s t;
        t.opcode = op;
        t.rd     = REG_ADDR_W'(rd);
        t.rs_imm = REG_ADDR_W'(rs);
        return t;
    endfunction

    function automatic decode_ctrl_s ref_ctrl(input logic [OPCODE_W-1:0] op, input bit byte_en);
        decode_ctrl_s c;
        bit legal;
        c = '0;
        legal = op inside {kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR, kSLT, kSLTU,
                           kMOV, kSLLR, kJALR, kLW, kLBU, kXOR, kROR, kSW, kSB,
                           kBEQZ, kBNEQZ, kJ};
        if (!byte_en && (op inside {kLBU, kSB})) legal = 1'b0;
        if (!legal) begin
            c.is_illegal = 1'b1;
            return c;
        end
        c.is_load   = op inside {kLW, kLBU};
        c.is_store  = op inside {kSW, kSB};
        c.is_mem    = c.is_load || c.is_store;
        c.is_byte   = op inside {kLBU, kSB};
        c.writes_rf = op inside {kADDU, kSUBU, kSLLV, kSRAV, kSRLV, kAND, kOR, kNOR, kSLT,
                                 kSLTU, kMOV, kSLLR, kJALR, kLW, kLBU, kXOR, kROR};
        return c;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, then check in_ready and any output transfer mid-cycle.
    task automatic step(input logic v, input instruction_s ins, input logic ordy,
                        input logic fl, input logic exp_rdy, input int exp_ov);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_instr  = ins;
        out_ready = ordy;
        flush     = fl;
        #2;
        chk("in_ready", 64'(in_ready_o), 64'(exp_rdy));
        if (exp_ov >= 0) chk("out_valid", 64'(out_valid_o), 64'(exp_ov));
        if (out_valid_o && ordy) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out", 64'(out_valid_o), 64'(0));
            end else begin
                e = exp_q.pop_front();
                chk("instr_o", 64'(instr_o), 64'(e.instr));
                chk("ctrl_o", 64'(ctrl_o), 64'(e.ctrl));
            end
        end
        if (v && exp_rdy) begin
            e.instr = ins;
            e.ctrl  = ref_ctrl(ins.opcode, 1'b1);
            exp_q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b1, -1);
    endtask

    initial begin
        instruction_s held;
        n_reset   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_instr  = '0;
        #2;
        chk("rst_out_valid", 64'(out_valid_o), 64'(0));
        chk("rst_instr", 64'(instr_o), 64'(0));
        chk("rst_ctrl", 64'(ctrl_o), 64'(0));
        chk("rst_stall", 64'(stall_cnt_o), 64'(0));
        @(posedge clk);
        #3 n_reset = 1'b1;

        // Mixed stream, no hazards; an illegal op reading a fresh load's rd must not stall.
        step(1, mk(kADDU, 1, 2), 1, 0, 1, 0);
        step(1, mk(kSUBU, 2, 3), 1, 0, 1, 1);
        step(1, mk(kLBU, 7, 1), 1, 0, 1, 1);
        step(1, mk(kUNDEF, 7, 7), 1, 0, 1, 1);
        step(1, mk(kSW, 4, 5), 1, 0, 1, 1);
        step(1, mk(kXOR, 8, 9), 1, 0, 1, 1);
        step(1, mk(kJ, 0, 0), 1, 0, 1, 1);
        idle(3);

        // Independent instruction after a load: back-to-back.
        step(1, mk(kLW, 3, 0), 1, 0, 1, -1);
        step(1, mk(kADDU, 5, 6), 1, 0, 1, 1);
        step(0, '0, 1, 0, 1, 1);
        chk("nodep_stall", 64'(stall_cnt_o), 64'(0));
        idle(3);

        // Load-use: exactly SB_DEPTH bubbles.
        step(1, mk(kLW, 3, 0), 1, 0, 1, -1);
        step(1, mk(kADDU, 4, 3), 1, 0, 0, 1);
        step(1, mk(kADDU, 4, 3), 1, 0, 0, 0);
        step(1, mk(kADDU, 4, 3), 1, 0, 1, 0);
        step(0, '0, 1, 0, 1, 1);
        chk("loaduse_stall", 64'(stall_cnt_o), 64'(2));
        idle(3);

        // Downstream stall with output full: everything holds.
        held = mk(kADDU, 1, 2);
        step(1, held, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, mk(kXOR, 8, 9), 0, 0, 0, 1);
            chk("hold_instr", 64'(instr_o), 64'(held));
            chk("hold_ctrl", 64'(ctrl_o), 64'(ref_ctrl(kADDU, 1'b1)));
        end
        chk("hold_stall", 64'(stall_cnt_o), 64'(2));
        step(1, mk(kXOR, 8, 9), 1, 0, 1, 1);
        idle(3);

        // Flush with the load in slot 1 and a dependent instruction waiting.
        step(1, mk(kLW, 3, 0), 1, 0, 1, -1);
        step(1, mk(kADDU, 4, 3), 1, 0, 0, 1);
        step(1, mk(kADDU, 4, 3), 1, 1, 0, 0);
        step(1, mk(kADDU, 4, 3), 1, 0, 1, 0);
        chk("flush_ctrl", 64'(ctrl_o), 64'(0));
        step(0, '0, 1, 0, 1, 1);
        chk("flush_stall", 64'(stall_cnt_o), 64'(3));
        idle(2);

        // Flush while the load is still in the output register: no stall afterwards.
        step(1, mk(kLW, 3, 0), 1, 0, 1, -1);
        step(1, mk(kADDU, 4, 3), 1, 1, 0, 1);
        step(1, mk(kADDU, 4, 3), 1, 0, 1, 0);
        step(0, '0, 1, 0, 1, 1);
        chk("flush2_stall", 64'(stall_cnt_o), 64'(3));
        idle(2);

        // Byte ops disabled; illegal right behind a load never interlocks.
        step(1, mk(kSB, 1, 2), 1, 0, 1, -1);
        step(1, mk(kLW, 3, 0), 1, 0, 1, 1);
        chk("nb_sb_valid", 64'(nb_out_valid), 64'(1));
        chk("nb_sb_ctrl", 64'(nb_ctrl), 64'(ref_ctrl(kSB, 1'b0)));
        chk("nb_sb_instr", 64'(nb_instr), 64'(mk(kSB, 1, 2)));
        step(1, mk(kUNDEF, 3, 3), 1, 0, 1, 1);
        chk("nb_ready", 64'(nb_in_ready), 64'(1));
        step(0, '0, 1, 0, 1, 1);
        chk("illegal_stall", 64'(stall_cnt_o), 64'(3));
        idle(2);

        // Asynchronous reset mid-stream.
        step(1, mk(kOR, 6, 7), 1, 0, 1, -1);
        step(1, mk(kAND, 8, 9), 1, 0, 1, 1);
        @(posedge clk);
        #2;
        n_reset  = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_out_valid", 64'(out_valid_o), 64'(0));
        chk("arst_ctrl", 64'(ctrl_o), 64'(0));
        chk("arst_instr", 64'(instr_o), 64'(0));
        chk("arst_stall", 64'(stall_cnt_o), 64'(0));
        exp_q.delete();
        #1 n_reset = 1'b1;
        step(1, mk(kADDU, 1, 2), 1, 0, 1, 0);
        step(0, '0, 1, 0, 1, 1);
        chk("post_rst_wrf", 64'(ctrl_o.writes_rf), 64'(1));

        idle(2);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
